// File: rtl/sc_io_pkg.sv
// Shared constants and helpers for the memory-mapped I/O unit.
package sc_io_pkg;

  // Word addresses within the 64-word I/O window
  localparam logic [5:0] IO_IN_BASE  = 6'h00;
  localparam logic [5:0] IO_OUT_BASE = 6'h10;
  localparam logic [5:0] IO_STATUS   = 6'h1F;

  // ceil(log2(n)) with a floor of 1 bit, for sizing counters
  function automatic int clog2w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_io_debounce.sv
// One input channel: two-flop synchroniser, debounce counter, accepted
// (stable) value and a single-cycle accept strobe for the change flag.
module sc_io_debounce
  import sc_io_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic            mem_clk,
  input  logic            reset,
  input  logic [IN_W-1:0] i_raw,
  output logic [IN_W-1:0] o_stable,
  output logic            o_chg
);

  localparam int            CW   = clog2w(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [IN_W-1:0] r_sync1;
  logic [IN_W-1:0] r_sync2;
  logic [IN_W-1:0] r_stable;
  logic [CW-1:0]   r_cnt;
  logic            w_accept;

  // The strobe is combinational from registered state so the top can set
  // the change flag on the same edge that updates the stable value.
  assign w_accept = (r_sync2 != r_stable) && (r_cnt == LAST);
  assign o_chg    = w_accept;
  assign o_stable = r_stable;

  // Synchronise, then count consecutive cycles that differ from the stable value
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped I/O unit: debounced switch inputs with sticky change flags,
// writable output registers and a programmable CPU clock divider.
module sc_io_ports
  import sc_io_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int IN_W      = 4,
  parameter int N_OUT     = 2,
  parameter int OUT_W     = 32,
  parameter int DB_CYCLES = 4,
  parameter int DIV_HALF  = 1
) (
  input  logic                   mem_clk,
  input  logic                   reset,
  input  logic [N_IN*IN_W-1:0]   in_raw,
  input  logic [5:0]             addr,
  input  logic                   sel,
  input  logic                   we,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic [N_OUT*OUT_W-1:0] out_port,
  output logic                   chg_irq,
  output logic                   cpu_clk
);

  localparam int            DW    = clog2w(DIV_HALF);
  localparam logic [DW-1:0] DLAST = DW'(DIV_HALF - 1);
  localparam logic [4:0]    NI5   = 5'(N_IN);
  localparam logic [4:0]    NO5   = 5'(N_OUT);

  logic [IN_W-1:0]  w_stable [N_IN];
  logic [N_IN-1:0]  w_chg;
  logic [N_IN-1:0]  w_clr;
  logic [31:0]      w_rd;
  logic             w_wr;
  logic             w_in_hit;
  logic             w_out_hit;

  logic [OUT_W-1:0] r_out [N_OUT];
  logic [N_IN-1:0]  r_flags;
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic [DW-1:0]    r_div;
  logic             r_cpu_clk;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_ch
      sc_io_debounce #(
        .IN_W      (IN_W),
        .DB_CYCLES (DB_CYCLES)
      ) u_db (
        .mem_clk  (mem_clk),
        .reset    (reset),
        .i_raw    (in_raw[gi*IN_W +: IN_W]),
        .o_stable (w_stable[gi]),
        .o_chg    (w_chg[gi])
      );
    end
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      assign out_port[gi*OUT_W +: OUT_W] = r_out[gi];
    end
  endgenerate

  // With N_OUT=16 the last output register would alias the status word;
  // status takes priority, so that register is not reachable.
  assign w_wr      = sel && we;
  assign w_in_hit  = (addr[5:4] == IO_IN_BASE[5:4]) && ({1'b0, addr[3:0]} < NI5);
  assign w_out_hit = (addr[5:4] == IO_OUT_BASE[5:4]) && ({1'b0, addr[3:0]} < NO5)
                     && (addr != IO_STATUS);
  assign w_clr     = (w_wr && (addr == IO_STATUS)) ? wdata[N_IN-1:0] : '0;

  assign rdata   = r_rdata;
  assign chg_irq = r_irq;
  assign cpu_clk = r_cpu_clk;

  // Read mux over the current (pre-write) state; unused high bits stay zero
  always_comb begin
    w_rd = '0;
    if (addr == IO_STATUS) begin
      w_rd[N_IN-1:0] = r_flags;
    end else if (w_in_hit) begin
      for (int i = 0; i < N_IN; i++) begin
        if (addr[3:0] == 4'(i)) w_rd[IN_W-1:0] = w_stable[i];
      end
    end else if (w_out_hit) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (addr[3:0] == 4'(j)) w_rd[OUT_W-1:0] = r_out[j];
      end
    end
  end

  // Registered read data, held while the window is not selected
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (sel) begin
      r_rdata <= w_rd;
    end
  end

  // Output registers
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N_OUT; j++) r_out[j] <= '0;
    end else if (w_wr && w_out_hit) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (addr[3:0] == 4'(j)) r_out[j] <= wdata[OUT_W-1:0];
      end
    end
  end

  // Sticky change flags (a new change beats a same-cycle clear) and the irq
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_flags <= (r_flags & ~w_clr) | w_chg;
      r_irq   <= |r_flags;
    end
  end

  // CPU clock divider: toggle every DIV_HALF mem_clk edges
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_cpu_clk <= 1'b0;
    end else if (r_div == DLAST) begin
      r_div     <= '0;
      r_cpu_clk <= ~r_cpu_clk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: tb/tb_sc_io_ports.sv
// Bench for sc_io_ports: directed scenarios plus randomized traffic against a
// behavioural model of the I/O unit.
module tb_sc_io_ports;

  localparam int N_IN = 2, IN_W = 4, N_OUT = 2, OUT_W = 32, DB = 4;

  logic        mem_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  in_raw  = '0;
  logic [5:0]  addr    = '0;
  logic        sel     = 1'b0;
  logic        we      = 1'b0;
  logic [31:0] wdata   = '0;
  logic [31:0] rdata;
  logic [63:0] out_port;
  logic        chg_irq;
  logic        cpu_clk;

  logic        rst3 = 1'b1;
  logic [7:0]  in_raw3 = '0;
  logic [5:0]  addr3 = '0;
  logic        sel3 = 1'b0, we3 = 1'b0;
  logic [31:0] wdata3 = '0;
  logic [31:0] rdata3;
  logic [63:0] out3;
  logic        irq3, cpu3;

  int checks = 0;
  int errors = 0;

  always #5 mem_clk = ~mem_clk;

  sc_io_ports #(.N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .OUT_W(OUT_W),
                .DB_CYCLES(DB), .DIV_HALF(1)) dut (
    .mem_clk(mem_clk), .reset(reset), .in_raw(in_raw), .addr(addr), .sel(sel),
    .we(we), .wdata(wdata), .rdata(rdata), .out_port(out_port),
    .chg_irq(chg_irq), .cpu_clk(cpu_clk));

  sc_io_ports #(.N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .OUT_W(OUT_W),
                .DB_CYCLES(DB), .DIV_HALF(3)) dut3 (
    .mem_clk(mem_clk), .reset(rst3), .in_raw(in_raw3), .addr(addr3), .sel(sel3),
    .we(we3), .wdata(wdata3), .rdata(rdata3), .out_port(out3),
    .chg_irq(irq3), .cpu_clk(cpu3));

  // ---------------- behavioural model ----------------
  int          n_edges, n3;
  logic [3:0]  m_d1 [2];
  logic [3:0]  m_d2 [2];
  logic [3:0]  m_stable [2];
  logic [3:0]  m_win [2][DB];
  int          m_fill [2];
  logic [1:0]  m_flags;
  logic        m_irq;
  logic [31:0] m_out [2];
  logic [31:0] m_rdata;

  function automatic logic [31:0] model_read(input logic [5:0] a);
    if (a < 6'd2) return {28'd0, m_stable[a[0]]};
    if (a == 6'h10 || a == 6'h11) return m_out[a[0]];
    if (a == 6'h1F) return {30'd0, m_flags};
    return 32'd0;
  endfunction

  task automatic model_reset();
    n_edges = 0; m_flags = '0; m_irq = 1'b0; m_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      m_d1[c] = '0; m_d2[c] = '0; m_stable[c] = '0; m_fill[c] = 0; m_out[c] = '0;
      for (int k = 0; k < DB; k++) m_win[c][k] = '0;
    end
  endtask

  // A new value is accepted once DB consecutive synced samples, all taken
  // since the last acceptance, differ from the accepted value.
  task automatic model_step();
    logic [31:0] rd;
    logic [1:0]  chg, clr;
    bit          all_diff;
    rd  = sel ? model_read(addr) : m_rdata;
    chg = '0;
    for (int c = 0; c < 2; c++) begin
      for (int k = DB - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
      m_win[c][0] = m_d2[c];
      m_fill[c]++;
      if (m_fill[c] >= DB) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) if (m_win[c][k] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[c] = m_d2[c];
          m_fill[c]   = 0;
          chg[c]      = 1'b1;
        end
      end
      m_d2[c] = m_d1[c];
      m_d1[c] = in_raw[c*4 +: 4];
    end
    clr     = (sel && we && addr == 6'h1F) ? wdata[1:0] : 2'b00;
    m_irq   = |m_flags;
    m_flags = (m_flags & ~clr) | chg;
    if (sel && we && addr == 6'h10) m_out[0] = wdata;
    if (sel && we && addr == 6'h11) m_out[1] = wdata;
    m_rdata = rd;
    n_edges++;
  endtask

  task automatic tick();
    @(posedge mem_clk);
    if (reset) model_reset(); else model_step();
    if (rst3) n3 = 0; else n3++;
    @(negedge mem_clk);
  endtask

  function automatic logic exp_cpu();
    return logic'(n_edges % 2);
  endfunction

  function automatic logic exp_cpu3();
    return logic'((n3 / 3) % 2);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; rst3 = 1'b1; model_reset(); n3 = 0;
    #2;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (out_port !== 64'd0) begin errors++; $display("FAIL reset_out got %h exp 0", out_port); end
    checks++; if (chg_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", chg_irq); end
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL reset_cpu got %b exp 0", cpu_clk); end
    checks++; if (cpu3 !== 1'b0) begin errors++; $display("FAIL reset_cpu3 got %b exp 0", cpu3); end
    tick();
    reset = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_div1();
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (cpu_clk !== logic'(i % 2)) begin
        errors++; $display("FAIL div1_cpu edge %0d got %b exp %b", i, cpu_clk, logic'(i % 2));
      end
    end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL div1_rdata got %h exp 0", rdata); end
    checks++; if (out_port !== 64'd0) begin errors++; $display("FAIL div1_out got %h exp 0", out_port); end
    checks++; if (chg_irq !== 1'b0) begin errors++; $display("FAIL div1_irq got %b exp 0", chg_irq); end
  endtask

  task automatic test_div3();
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (cpu3 !== exp_cpu3()) begin
        errors++; $display("FAIL div3_cpu edge %0d got %b exp %b", i, cpu3, exp_cpu3());
      end
    end
    while (n3 % 6 != 4) tick();
    checks++; if (cpu3 !== 1'b1) begin errors++; $display("FAIL div3_midhigh got %b exp 1", cpu3); end
    rst3 = 1'b1;
    #1;
    checks++; if (cpu3 !== 1'b0) begin errors++; $display("FAIL div3_async_rst got %b exp 0", cpu3); end
    tick(); rst3 = 1'b0;
  endtask

  task automatic test_ch0();
    in_raw[3:0] = 4'hA; addr = 6'h00; sel = 1'b1; we = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (rdata !== m_rdata) begin errors++; $display("FAIL ch0_model k=%0d got %h exp %h", k, rdata, m_rdata); end
      if (k == 6) begin
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL ch0_early got %h exp 0", rdata); end
      end
      if (k == 7) begin
        checks++; if (rdata !== 32'hA) begin errors++; $display("FAIL ch0_accept got %h exp 0000000a", rdata); end
      end
    end
    addr = 6'h1F;
    tick();
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL ch0_status got %h exp 1", rdata); end
    checks++; if (chg_irq !== 1'b1) begin errors++; $display("FAIL ch0_irq got %b exp 1", chg_irq); end
  endtask

  task automatic test_bounce();
    addr = 6'h1F; sel = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_raw[7:4] = (k == 4) ? 4'h0 : 4'h3;
      tick();
      checks++;
      if (rdata[1] !== logic'(k >= 11)) begin
        errors++; $display("FAIL bounce_flag k=%0d got %b exp %b", k, rdata[1], logic'(k >= 11));
      end
      checks++;
      if (rdata !== m_rdata) begin errors++; $display("FAIL bounce_model k=%0d got %h exp %h", k, rdata, m_rdata); end
    end
    addr = 6'h01; tick(); tick();
    checks++; if (rdata !== 32'h3) begin errors++; $display("FAIL bounce_value got %h exp 3", rdata); end
  endtask

  task automatic test_outputs();
    sel = 1'b1; we = 1'b1; addr = 6'h10; wdata = 32'hDEADBEEF; tick();
    addr = 6'h11; wdata = 32'h5; tick();
    we = 1'b0;
    checks++;
    if (out_port !== {32'h5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL out_port got %h exp 00000005deadbeef", out_port);
    end
    addr = 6'h10; tick();
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL out_read got %h exp deadbeef", rdata); end
    addr = 6'h11; we = 1'b1; wdata = 32'h1234_5678; tick();
    checks++; if (rdata !== 32'h5) begin errors++; $display("FAIL rdw_old got %h exp 5", rdata); end
    we = 1'b0; tick();
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL rdw_new got %h exp 12345678", rdata); end
    addr = 6'h05; we = 1'b1; wdata = 32'hFFFF_FFFF; tick();
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL unmapped got %h exp 0", rdata); end
    addr = 6'h00; tick(); we = 1'b0; tick();
    checks++; if (rdata !== 32'hA) begin errors++; $display("FAIL in_readonly got %h exp a", rdata); end
    sel = 1'b0; addr = 6'h10; tick();
    checks++; if (rdata !== 32'hA) begin errors++; $display("FAIL rdata_hold got %h exp a", rdata); end
    checks++;
    if (out_port !== {32'h1234_5678, 32'hDEADBEEF}) begin
      errors++; $display("FAIL out_after got %h exp 12345678deadbeef", out_port);
    end
  endtask

  task automatic test_w1c();
    in_raw[3:0] = 4'h5; sel = 1'b0; we = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    sel = 1'b1; we = 1'b1; addr = 6'h1F; wdata = 32'h1; tick();
    wdata = 32'h0; tick();
    checks++; if (rdata !== 32'h3) begin errors++; $display("FAIL w1c_setwins got %h exp 3", rdata); end
    we = 1'b0; tick();
    checks++; if (rdata !== 32'h3) begin errors++; $display("FAIL w1c_zero got %h exp 3", rdata); end
    we = 1'b1; wdata = 32'h3; tick();
    checks++; if (chg_irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag got %b exp 1", chg_irq); end
    we = 1'b0; tick();
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h exp 0", rdata); end
    checks++; if (chg_irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop got %b exp 0", chg_irq); end
  endtask

  task automatic test_random();
    logic [5:0] picks [8];
    picks = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h1F, 6'h05};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) in_raw[$urandom_range(0, 1)*4 +: 4] = 4'($urandom);
      addr  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : picks[$urandom_range(0, 7)];
      sel   = ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      tick();
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata i=%0d got %h exp %h", i, rdata, m_rdata); end
      checks++;
      if (out_port !== {m_out[1], m_out[0]}) begin
        errors++; $display("FAIL rnd_out i=%0d got %h exp %h", i, out_port, {m_out[1], m_out[0]});
      end
      checks++; if (chg_irq !== m_irq) begin errors++; $display("FAIL rnd_irq i=%0d got %b exp %b", i, chg_irq, m_irq); end
      checks++; if (cpu_clk !== exp_cpu()) begin errors++; $display("FAIL rnd_cpu i=%0d got %b exp %b", i, cpu_clk, exp_cpu()); end
      checks++; if (cpu3 !== exp_cpu3()) begin errors++; $display("FAIL rnd_cpu3 i=%0d got %b exp %b", i, cpu3, exp_cpu3()); end
    end
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_rdata got %h exp 0", rdata); end
    checks++; if (out_port !== 64'd0) begin errors++; $display("FAIL mid_rst_out got %h exp 0", out_port); end
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL mid_rst_cpu got %b exp 0", cpu_clk); end
    tick();
    reset = 1'b0; in_raw = '0; addr = 6'h1F; sel = 1'b1;
    tick(); tick();
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_flags got %h exp 0", rdata); end
    checks++; if (chg_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b exp 0", chg_irq); end
  endtask

  initial begin
    @(negedge mem_clk);
    test_reset();
    test_div1();
    test_div3();
    test_ch0();
    test_bounce();
    test_outputs();
    test_w1c();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
